// File: rtl/mod_param_fetch_pkg.sv
// Shared types and default sizes for the parameter-fetch block and its datapath.
package mod_param_fetch_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 16;
  localparam int DEF_IN_DEPTH = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/mod_param_fetch_n_pipe.sv
// Three-stage stall-able fetch datapath: S0 element address, S1 weight/index data,
// S2 input/weight pair. Optional bounds check enabled by PARAM_FETCH_BOUNDS_EN.
module mod_fetch_pipe
  import mod_param_fetch_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int IN_DEPTH = DEF_IN_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_i,
  input  logic          issue_vld_i,
  input  logic          issue_last_i,
  input  logic [AW-1:0] issue_idx_i,
  input  logic [AW-1:0] offset_i,
  input  logic [AW-1:0] index_offset_i,
  input  logic [AW-1:0] weight_offset_i,
  output logic [AW-1:0] weight_addr_o,
  output logic [AW-1:0] index_addr_o,
  input  logic [DW-1:0] weight_val_i,
  input  logic [DW-1:0] index_val_i,
  output logic [AW-1:0] input_addr_o,
  input  logic [DW-1:0] input_val_i,
  output logic [DW-1:0] out_val_o,
  output logic [DW-1:0] out_weight_o,
  output logic          out_valid_o,
  output logic          out_last_o,
  output logic          s1_last_o,
  output logic          oob_o
);

`ifdef PARAM_FETCH_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(IN_DEPTH);

  logic          s0_vld_q, s0_last_q;
  logic [AW-1:0] s0_idx_q;
  logic          s1_vld_q, s1_last_q;
  logic [DW-1:0] s1_w_q, s1_ix_q;
  logic          s2_vld_q, s2_last_q;
  logic [DW-1:0] s2_val_q, s2_w_q;

  logic [AW-1:0] ix_aw;
  logic [AW:0]   in_sum;
  logic          oob;
  logic [DW-1:0] in_sel;

  assign weight_addr_o = s0_idx_q + weight_offset_i;
  assign index_addr_o  = s0_idx_q + index_offset_i;

  assign ix_aw        = AW'(s1_ix_q);
  assign input_addr_o = ix_aw + offset_i;

  // Out-of-range test uses one extra bit so a wrapping sum still counts as out of range.
  assign in_sum = {1'b0, ix_aw} + {1'b0, offset_i};
  assign oob    = BOUNDS_EN && s1_vld_q && (in_sum >= DEPTH_LIM);
  assign in_sel = oob ? '0 : input_val_i;
  assign oob_o  = oob;

  assign s1_last_o    = s1_vld_q & s1_last_q;
  assign out_val_o    = s2_val_q;
  assign out_weight_o = s2_w_q;
  assign out_valid_o  = s2_vld_q;
  assign out_last_o   = s2_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_vld_q  <= 1'b0;
      s0_last_q <= 1'b0;
      s0_idx_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_w_q    <= '0;
      s1_ix_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_val_q  <= '0;
      s2_w_q    <= '0;
    end else if (!stall_i) begin
      // S0: element address
      s0_vld_q  <= issue_vld_i;
      s0_last_q <= issue_vld_i & issue_last_i;
      s0_idx_q  <= issue_idx_i;
      // S1: weight and index read data
      s1_vld_q  <= s0_vld_q;
      s1_last_q <= s0_last_q;
      s1_w_q    <= weight_val_i;
      s1_ix_q   <= index_val_i;
      // S2: output pair
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_val_q  <= in_sel;
      s2_w_q    <= s1_w_q;
    end
  end

endmodule

// File: rtl/mod_param_fetch_n.sv
// Parameter-fetch controller: FSM and element counter driving the fetch datapath.
// Optional bounds checking enabled by defining PARAM_FETCH_BOUNDS_EN.
module mod_param_fetch_n
  import mod_param_fetch_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int IN_DEPTH = DEF_IN_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] num_adds,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] index_offset,
  input  logic [AW-1:0] weight_offset,
  input  logic          stall,
  output logic [AW-1:0] weight_addr,
  output logic [AW-1:0] index_addr,
  input  logic [DW-1:0] weight_val,
  input  logic [DW-1:0] index_val,
  output logic [AW-1:0] input_addr,
  input  logic [DW-1:0] input_val,
  output logic [DW-1:0] out_val,
  output logic [DW-1:0] out_weight,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] ONE = AW'(1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] off_q, off_d;
  logic [AW-1:0] ioff_q, ioff_d;
  logic [AW-1:0] woff_q, woff_d;
  logic          err_q, err_d;

  logic          iss_vld, iss_last;
  logic [AW-1:0] iss_idx;
  logic          s1_last, oob;

  // The accepting start edge issues element 0, so the counter leaves IDLE at 1.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    n_d      = n_q;
    off_d    = off_q;
    ioff_d   = ioff_q;
    woff_d   = woff_q;
    err_d    = err_q | oob;
    iss_vld  = 1'b0;
    iss_last = 1'b0;
    iss_idx  = i_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = num_adds;
          off_d  = offset;
          ioff_d = index_offset;
          woff_d = weight_offset;
          i_d    = '0;
          err_d  = 1'b0;
          if (num_adds == '0) begin
            state_d = DONE;
          end else begin
            iss_vld  = 1'b1;
            iss_idx  = '0;
            iss_last = (num_adds == ONE);
            i_d      = ONE;
            state_d  = (num_adds == ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        iss_vld  = 1'b1;
        iss_last = (i_q == n_q - ONE);
        i_d      = i_q + ONE;
        if (iss_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (s1_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      n_q     <= '0;
      off_q   <= '0;
      ioff_q  <= '0;
      woff_q  <= '0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      i_q     <= i_d;
      n_q     <= n_d;
      off_q   <= off_d;
      ioff_q  <= ioff_d;
      woff_q  <= woff_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

  mod_fetch_pipe #(
    .DW       (DW),
    .AW       (AW),
    .IN_DEPTH (IN_DEPTH)
  ) u_pipe (
    .clk_i           (clk),
    .rst_ni          (rst),
    .stall_i         (stall),
    .issue_vld_i     (iss_vld),
    .issue_last_i    (iss_last),
    .issue_idx_i     (iss_idx),
    .offset_i        (off_q),
    .index_offset_i  (ioff_q),
    .weight_offset_i (woff_q),
    .weight_addr_o   (weight_addr),
    .index_addr_o    (index_addr),
    .weight_val_i    (weight_val),
    .index_val_i     (index_val),
    .input_addr_o    (input_addr),
    .input_val_i     (input_val),
    .out_val_o       (out_val),
    .out_weight_o    (out_weight),
    .out_valid_o     (out_valid),
    .out_last_o      (out_last),
    .s1_last_o       (s1_last),
    .oob_o           (oob)
  );

endmodule

// File: tb/tb_mod_param_fetch_n.sv
// Directed self-checking bench for mod_param_fetch_n with asynchronous-read memory models.
module tb_mod_param_fetch_n;

  localparam int DW = 16;
  localparam int AW = 16;
`ifdef PARAM_FETCH_BOUNDS_EN
  localparam int TB_DEPTH = 16;
  localparam bit BEN      = 1'b1;
`else
  localparam int TB_DEPTH = 65536;
  localparam bit BEN      = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] num_adds = '0;
  logic [AW-1:0] offset = '0;
  logic [AW-1:0] index_offset = '0;
  logic [AW-1:0] weight_offset = '0;
  logic [AW-1:0] weight_addr, index_addr, input_addr;
  logic [DW-1:0] weight_val, index_val, input_val;
  logic [DW-1:0] out_val, out_weight;
  logic          out_valid, out_last, busy, done, err;

  logic [DW-1:0] w_mem   [0:65535];
  logic [DW-1:0] idx_mem [0:65535];

  int tests_run    = 0;
  int tests_failed = 0;

  assign weight_val = w_mem[weight_addr];
  assign index_val  = idx_mem[index_addr];
  assign input_val  = input_addr ^ 16'h5A5A;

  always #5 clk = ~clk;

  mod_param_fetch_n #(
    .DW       (DW),
    .AW       (AW),
    .IN_DEPTH (TB_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_adds      (num_adds),
    .offset        (offset),
    .index_offset  (index_offset),
    .weight_offset (weight_offset),
    .stall         (stall),
    .weight_addr   (weight_addr),
    .index_addr    (index_addr),
    .weight_val    (weight_val),
    .index_val     (index_val),
    .input_addr    (input_addr),
    .input_val     (input_val),
    .out_val       (out_val),
    .out_weight    (out_weight),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  function automatic logic [15:0] exp_in(input int a);
    if (BEN && a >= TB_DEPTH) return 16'h0000;
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int off, input int ioff, input int woff);
    num_adds      = AW'(n);
    offset        = AW'(off);
    index_offset  = AW'(ioff);
    weight_offset = AW'(woff);
    start         = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0 || out_val !== 16'h0 || out_weight !== 16'h0)
      begin tests_failed++;
        $display("FAIL reset_async ctl=%b val=%h w=%h required ctl=00000 val=0 w=0",
                 {out_valid, out_last, busy, done, err}, out_val, out_weight); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, busy, done, err} !== 4'b0)
      begin tests_failed++;
        $display("FAIL reset_idle ctl=%b required 0000", {out_valid, busy, done, err}); end
  endtask

  task automatic test_basic();
    int k;
    logic vld;
    logic [3:0] ctl_exp;
    for (int j = 0; j < 4; j++) begin
      w_mem[16'h100 + j]   = 16'(j + 1);
      idx_mem[16'h200 + j] = 16'(j);
    end
    launch(4, 'h10, 'h200, 'h100);
    for (int c = 0; c < 7; c++) begin
      tick();
      start = 1'b0;
      k = c - 2;
      vld = (k >= 0 && k < 4);
      ctl_exp = {vld, k == 3, c == 5, c <= 5};
      tests_run++;
      if ({out_valid, out_last, done, busy} !== ctl_exp)
        begin tests_failed++;
          $display("FAIL basic_ctl c=%0d got %b required %b", c, {out_valid, out_last, done, busy}, ctl_exp); end
      if (vld) begin
        tests_run++;
        if (out_val !== exp_in(16 + k) || out_weight !== 16'(k + 1))
          begin tests_failed++;
            $display("FAIL basic_pair c=%0d got %h/%h required %h/%h", c, out_val, out_weight,
                     exp_in(16 + k), 16'(k + 1)); end
      end
      if (c < 4) begin
        tests_run++;
        if (weight_addr !== 16'(16'h100 + c) || index_addr !== 16'(16'h200 + c))
          begin tests_failed++;
            $display("FAIL basic_addr c=%0d got %h/%h required %h/%h", c, weight_addr, index_addr,
                     16'(16'h100 + c), 16'(16'h200 + c)); end
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0] ctl_exp;
    launch(0, 'h10, 'h200, 'h100);
    for (int c = 0; c < 2; c++) begin
      tick();
      start = 1'b0;
      ctl_exp = {1'b0, 1'b0, c == 0, c == 0};
      tests_run++;
      if ({out_valid, out_last, done, busy} !== ctl_exp)
        begin tests_failed++;
          $display("FAIL zero_ctl c=%0d got %b required %b", c, {out_valid, out_last, done, busy}, ctl_exp); end
    end
  endtask

  task automatic test_stall();
    int exp_k [11] = '{-1, -1, 0, 1, 1, 1, 1, 2, 3, 4, -1};
    logic vld;
    logic [3:0] ctl_exp;
    for (int j = 0; j < 5; j++) begin
      w_mem[16'h100 + j]   = 16'(j + 1);
      idx_mem[16'h200 + j] = 16'(j);
    end
    launch(5, 'h10, 'h200, 'h100);
    for (int c = 0; c < 11; c++) begin
      stall = (c >= 4 && c <= 6);
      tick();
      start = 1'b0;
      vld = (exp_k[c] >= 0);
      ctl_exp = {vld, exp_k[c] == 4, c == 9, c <= 9};
      tests_run++;
      if ({out_valid, out_last, done, busy} !== ctl_exp)
        begin tests_failed++;
          $display("FAIL stall_ctl c=%0d got %b required %b", c, {out_valid, out_last, done, busy}, ctl_exp); end
      if (vld) begin
        tests_run++;
        if (out_val !== exp_in(16 + exp_k[c]) || out_weight !== 16'(exp_k[c] + 1))
          begin tests_failed++;
            $display("FAIL stall_pair c=%0d got %h/%h required %h/%h", c, out_val, out_weight,
                     exp_in(16 + exp_k[c]), 16'(exp_k[c] + 1)); end
      end
      if (c >= 3 && c <= 6) begin
        tests_run++;
        if (weight_addr !== 16'h0103)
          begin tests_failed++;
            $display("FAIL stall_addr_hold c=%0d got %h required 0103", c, weight_addr); end
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_abort();
    int k;
    logic vld;
    logic [3:0] ctl_exp;
    for (int j = 0; j < 6; j++) begin
      w_mem[16'h100 + j]   = 16'(j + 1);
      idx_mem[16'h200 + j] = 16'(j);
    end
    launch(6, 'h10, 'h200, 'h100);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0 || out_val !== 16'h0 || out_weight !== 16'h0)
      begin tests_failed++;
        $display("FAIL abort_async ctl=%b val=%h w=%h required 0", {out_valid, out_last, busy, done, err},
                 out_val, out_weight); end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if ({out_valid, done, busy} !== 3'b0)
        begin tests_failed++;
          $display("FAIL abort_quiet c=%0d got %b required 000", c, {out_valid, done, busy}); end
    end
    launch(2, 'h10, 'h200, 'h100);
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
      k = c - 2;
      vld = (k >= 0 && k < 2);
      ctl_exp = {vld, k == 1, c == 3, c <= 3};
      tests_run++;
      if ({out_valid, out_last, done, busy} !== ctl_exp)
        begin tests_failed++;
          $display("FAIL abort_rerun_ctl c=%0d got %b required %b", c, {out_valid, out_last, done, busy}, ctl_exp); end
      if (vld) begin
        tests_run++;
        if (out_val !== exp_in(16 + k) || out_weight !== 16'(k + 1))
          begin tests_failed++;
            $display("FAIL abort_rerun_pair c=%0d got %h/%h required %h/%h", c, out_val, out_weight,
                     exp_in(16 + k), 16'(k + 1)); end
      end
    end
  endtask

  task automatic test_wrap_and_ignore();
    int k;
    logic vld;
    logic [3:0] ctl_exp;
    logic [15:0] w_exp [2] = '{16'hAAAA, 16'hBBBB};
    w_mem[16'hFFFF] = 16'hAAAA;
    w_mem[16'h0000] = 16'hBBBB;
    idx_mem[16'h200] = 16'h0000;
    idx_mem[16'h201] = 16'h0001;
    launch(2, 'h10, 'h200, 'hFFFF);
    for (int c = 0; c < 5; c++) begin
      start    = (c <= 1);
      num_adds = (c == 0) ? 16'd2 : 16'd9;
      tick();
      k = c - 2;
      vld = (k >= 0 && k < 2);
      ctl_exp = {vld, k == 1, c == 3, c <= 3};
      tests_run++;
      if ({out_valid, out_last, done, busy} !== ctl_exp)
        begin tests_failed++;
          $display("FAIL wrap_ctl c=%0d got %b required %b", c, {out_valid, out_last, done, busy}, ctl_exp); end
      if (c < 2) begin
        tests_run++;
        if (weight_addr !== ((c == 0) ? 16'hFFFF : 16'h0000))
          begin tests_failed++;
            $display("FAIL wrap_addr c=%0d got %h required %h", c, weight_addr,
                     (c == 0) ? 16'hFFFF : 16'h0000); end
      end
      if (vld) begin
        tests_run++;
        if (out_val !== exp_in(16 + k) || out_weight !== w_exp[k])
          begin tests_failed++;
            $display("FAIL wrap_pair c=%0d got %h/%h required %h/%h", c, out_val, out_weight,
                     exp_in(16 + k), w_exp[k]); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_bounds();
    idx_mem[16'h300] = 16'd15;
    idx_mem[16'h301] = 16'd3;
    w_mem[16'h100]   = 16'd1;
    w_mem[16'h101]   = 16'd2;
    launch(2, 1, 'h300, 'h100);
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      if (c == 0) begin
        tests_run++;
        if (err !== 1'b0)
          begin tests_failed++; $display("FAIL bounds_err_start got %b required 0", err); end
      end
      if (c == 2 || c == 3) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_val !== exp_in((c == 2) ? 16 : 4) || err !== BEN)
          begin tests_failed++;
            $display("FAIL bounds_pair c=%0d got v=%b val=%h err=%b required v=1 val=%h err=%b", c,
                     out_valid, out_val, err, exp_in((c == 2) ? 16 : 4), BEN); end
      end
    end
    tick();
    tests_run++;
    if (err !== BEN)
      begin tests_failed++; $display("FAIL bounds_err_sticky got %b required %b", err, BEN); end
    launch(0, 0, 0, 0);
    tick();
    start = 1'b0;
    tests_run++;
    if (err !== 1'b0 || done !== 1'b1)
      begin tests_failed++; $display("FAIL bounds_err_clear got err=%b done=%b required 0/1", err, done); end
    tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      w_mem[a]   = '0;
      idx_mem[a] = '0;
    end
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_reset_abort();
    test_wrap_and_ignore();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
